ppu_hoam_sched: RTL and testbench

PPU_HOAM_SCHED -- requirements
Module: ppu_hoam_sched

---
 rtl/ppu_hoam_sched.sv | 212 +++++++++++++++++++++
 tb/tb_ppu_hoam_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_hoam_sched.sv
// High-OAM table scheduler: zero-fills the 32-byte high table, scans its 128
// two-bit sprite fields in index order, and shares the byte port with the CPU.
module ppu_hoam_sched (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr_start,
    input  logic       scan_start,
    input  logic       scan_abort,
    input  logic [6:0] first_sprite,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [4:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,
    output logic       clr_busy,
    output logic       scan_busy,
    output logic       spr_valid,
    output logic [6:0] spr_idx,
    output logic [1:0] spr_bits,
    output logic       scan_done,
    output logic [4:0] ram_addr_a,
    output logic [7:0] ram_data_a,
    output logic       ram_wren_a,
    input  logic [7:0] ram_q_a,
    output logic [6:0] ram_addr_b,
    input  logic [1:0] ram_q_b
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SCAN  = 2'd2
    } state_e;

    state_e     state_q,      state_d;
    logic       clr_busy_q,   clr_busy_d;
    logic       scan_busy_q,  scan_busy_d;
    logic       issuing_q,    issuing_d;
    logic [7:0] scan_cnt_q,   scan_cnt_d;
    logic [6:0] ram_addr_b_q, ram_addr_b_d;
    logic       spr_valid_q,  spr_valid_d;
    logic [6:0] spr_idx_q,    spr_idx_d;
    logic       scan_done_q,  scan_done_d;
    logic [4:0] ram_addr_a_q, ram_addr_a_d;
    logic [7:0] ram_data_a_q, ram_data_a_d;
    logic       ram_wren_a_q, ram_wren_a_d;
    logic       cpu_ack_q,    cpu_ack_d;
    logic       rd_pend_q,    rd_pend_d;
    logic       cpu_rvalid_q, cpu_rvalid_d;
    logic [7:0] rdata_hold_q, rdata_hold_d;
    logic [1:0] bits_hold_q,  bits_hold_d;

    logic clr_last;
    logic cpu_accept;

    // The final clear cycle may accept a waiting CPU request so it is acked
    // on the first cycle after the clear; a clr_start in IDLE blocks
    // acceptance because both would need port A on the following cycle.
    assign clr_last   = (state_q == ST_CLEAR) && (ram_addr_a_q == 5'd31);
    assign cpu_accept = cpu_req && !cpu_ack_q &&
                        (((state_q == ST_IDLE) && !clr_start) ||
                         (state_q == ST_SCAN) || clr_last);

    always_comb begin
        // NOTE: every next-state value gets a default before any branch, so
        // no path leaves a variable unassigned and no latch is inferred.
        state_d      = state_q;
        clr_busy_d   = clr_busy_q;
        scan_busy_d  = scan_busy_q;
        issuing_d    = issuing_q;
        scan_cnt_d   = scan_cnt_q;
        ram_addr_b_d = ram_addr_b_q;
        spr_valid_d  = 1'b0;
        spr_idx_d    = spr_idx_q;
        scan_done_d  = 1'b0;
        ram_addr_a_d = ram_addr_a_q;
        ram_data_a_d = ram_data_a_q;
        ram_wren_a_d = 1'b0;
        cpu_ack_d    = 1'b0;
        rd_pend_d    = 1'b0;
        cpu_rvalid_d = rd_pend_q;
        rdata_hold_d = cpu_rvalid_q ? ram_q_a : rdata_hold_q;
        bits_hold_d  = spr_valid_q  ? ram_q_b : bits_hold_q;

        unique case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d      = ST_CLEAR;
                    clr_busy_d   = 1'b1;
                    ram_addr_a_d = 5'd0;
                    ram_data_a_d = 8'h00;
                    ram_wren_a_d = 1'b1;
                end else if (scan_start) begin
                    state_d      = ST_SCAN;
                    scan_busy_d  = 1'b1;
                    issuing_d    = 1'b1;
                    scan_cnt_d   = 8'd1;
                    ram_addr_b_d = first_sprite;
                end
            end

            ST_CLEAR: begin
                if (clr_last) begin
                    state_d    = ST_IDLE;
                    clr_busy_d = 1'b0;
                end else begin
                    ram_addr_a_d = ram_addr_a_q + 5'd1;
                    ram_data_a_d = 8'h00;
                    ram_wren_a_d = 1'b1;
                end
            end

            ST_SCAN: begin
                if (scan_abort) begin
                    // The read issued this cycle is dropped: spr_valid stays low.
                    state_d     = ST_IDLE;
                    scan_busy_d = 1'b0;
                    issuing_d   = 1'b0;
                end else begin
                    spr_valid_d = issuing_q;
                    if (issuing_q) begin
                        spr_idx_d = ram_addr_b_q;
                        if (scan_cnt_q == 8'd128) begin
                            issuing_d   = 1'b0;
                            scan_done_d = 1'b1;
                        end else begin
                            ram_addr_b_d = ram_addr_b_q + 7'd1;
                            scan_cnt_d   = scan_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d     = ST_IDLE;
                        scan_busy_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cpu_accept) begin
            cpu_ack_d    = 1'b1;
            ram_addr_a_d = cpu_addr;
            ram_data_a_d = cpu_wdata;
            ram_wren_a_d = cpu_we;
            rd_pend_d    = !cpu_we;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values settled before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clr_busy_q   <= 1'b0;
            scan_busy_q  <= 1'b0;
            issuing_q    <= 1'b0;
            scan_cnt_q   <= 8'd0;
            ram_addr_b_q <= 7'd0;
            spr_valid_q  <= 1'b0;
            spr_idx_q    <= 7'd0;
            scan_done_q  <= 1'b0;
            ram_addr_a_q <= 5'd0;
            ram_data_a_q <= 8'h00;
            ram_wren_a_q <= 1'b0;
            cpu_ack_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            rdata_hold_q <= 8'h00;
            bits_hold_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            clr_busy_q   <= clr_busy_d;
            scan_busy_q  <= scan_busy_d;
            issuing_q    <= issuing_d;
            scan_cnt_q   <= scan_cnt_d;
            ram_addr_b_q <= ram_addr_b_d;
            spr_valid_q  <= spr_valid_d;
            spr_idx_q    <= spr_idx_d;
            scan_done_q  <= scan_done_d;
            ram_addr_a_q <= ram_addr_a_d;
            ram_data_a_q <= ram_data_a_d;
            ram_wren_a_q <= ram_wren_a_d;
            cpu_ack_q    <= cpu_ack_d;
            rd_pend_q    <= rd_pend_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            rdata_hold_q <= rdata_hold_d;
            bits_hold_q  <= bits_hold_d;
        end
    end

    // RAM read data is already registered inside the RAM; it is forwarded in
    // its valid cycle and captured so the value holds afterwards.
    assign cpu_rdata  = cpu_rvalid_q ? ram_q_a : rdata_hold_q;
    assign spr_bits   = spr_valid_q  ? ram_q_b : bits_hold_q;

    assign cpu_ack    = cpu_ack_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign clr_busy   = clr_busy_q;
    assign scan_busy  = scan_busy_q;
    assign spr_valid  = spr_valid_q;
    assign spr_idx    = spr_idx_q;
    assign scan_done  = scan_done_q;
    assign ram_addr_a = ram_addr_a_q;
    assign ram_data_a = ram_data_a_q;
    assign ram_wren_a = ram_wren_a_q;
    assign ram_addr_b = ram_addr_b_q;

endmodule

// File: tb/tb_ppu_hoam_sched.sv
// Bench for ppu_hoam_sched: dual-port high-table RAM model plus a byte-array
// reference of the table, with directed and randomized scenarios.
module tb_ppu_hoam_sched;

    logic       clock;
    logic       reset;
    logic       clr_start;
    logic       scan_start;
    logic       scan_abort;
    logic [6:0] first_sprite;
    logic       cpu_req;
    logic       cpu_we;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       cpu_rvalid;
    logic       clr_busy;
    logic       scan_busy;
    logic       spr_valid;
    logic [6:0] spr_idx;
    logic [1:0] spr_bits;
    logic       scan_done;
    logic [4:0] ram_addr_a;
    logic [7:0] ram_data_a;
    logic       ram_wren_a;
    logic [7:0] ram_q_a;
    logic [6:0] ram_addr_b;
    logic [1:0] ram_q_b;

    int n_checks;
    int n_fail;

    logic [7:0] ram_mem [32];
    logic [7:0] ref_mem [32];
    logic [1:0] scan_got [128];

    ppu_hoam_sched dut (
        .clock(clock), .reset(reset),
        .clr_start(clr_start), .scan_start(scan_start), .scan_abort(scan_abort),
        .first_sprite(first_sprite),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .clr_busy(clr_busy), .scan_busy(scan_busy),
        .spr_valid(spr_valid), .spr_idx(spr_idx), .spr_bits(spr_bits), .scan_done(scan_done),
        .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_wren_a(ram_wren_a),
        .ram_q_a(ram_q_a), .ram_addr_b(ram_addr_b), .ram_q_b(ram_q_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [1:0] field_of(input logic [7:0] b, input logic [1:0] sel);
        logic [7:0] sh;
        sh = b >> (2 * sel);
        return sh[1:0];
    endfunction

    // Sprite i lives in byte i/4, bit pair i%4; both ports see one storage.
    always @(posedge clock) begin
        if (ram_wren_a) ram_mem[ram_addr_a] <= ram_data_a;
        ram_q_a <= ram_mem[ram_addr_a];
        ram_q_b <= field_of(ram_mem[ram_addr_b[6:2]], ram_addr_b[1:0]);
    end

    function automatic logic [1:0] exp_bits(input int idx);
        return field_of(ref_mem[idx / 4], 2'(idx % 4));
    endfunction

    function automatic logic [43:0] all_outs();
        return {cpu_ack, cpu_rdata, cpu_rvalid, clr_busy, scan_busy, spr_valid,
                spr_idx, spr_bits, scan_done, ram_addr_a, ram_data_a, ram_wren_a, ram_addr_b};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [4:0] addr,
                              input logic [7:0] wdata, input logic [7:0] exp_rd);
        int waited;
        waited = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        do begin
            tick();
            waited++;
        end while (!cpu_ack && waited < 50);
        n_checks++;
        if (!cpu_ack) begin
            n_fail++;
            $display("FAIL cpu_ack_timeout addr=%0d: no ack within %0d cycles", addr, waited);
            cpu_req = 1'b0;
            return;
        end
        n_checks++;
        if ({ram_addr_a, ram_wren_a, cpu_rvalid} !== {addr, we, 1'b0} ||
            (we && ram_data_a !== wdata)) begin
            n_fail++;
            $display("FAIL cpu_port_a: got addr=%0d wren=%b data=%h rvalid=%b, want addr=%0d wren=%b data=%h rvalid=0",
                     ram_addr_a, ram_wren_a, ram_data_a, cpu_rvalid, addr, we, wdata);
        end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_ack, cpu_rvalid} !== {1'b0, !we} || (!we && cpu_rdata !== exp_rd)) begin
            n_fail++;
            $display("FAIL cpu_rvalid_n2: got ack=%b rvalid=%b rdata=%h, want ack=0 rvalid=%b rdata=%h",
                     cpu_ack, cpu_rvalid, cpu_rdata, !we, exp_rd);
        end
        tick();
        n_checks++;
        if (cpu_rvalid !== 1'b0 || (!we && cpu_rdata !== exp_rd)) begin
            n_fail++;
            $display("FAIL cpu_rdata_hold: got rvalid=%b rdata=%h, want rvalid=0 rdata=%h",
                     cpu_rvalid, cpu_rdata, exp_rd);
        end
        if (we) ref_mem[addr] = wdata;
    endtask

    // Runs a scan from first; abort_at (0 = none, else < 129) is the scan
    // cycle, counted from 1 after scan_start, in which scan_abort is raised.
    task automatic run_scan(input logic [6:0] first, input int abort_at);
        int active_end;
        int issue_end;
        int n_valid;
        int exp_valid_cnt;
        logic [6:0] exp_idx;
        active_end = (abort_at != 0) ? abort_at : 129;
        issue_end  = (active_end < 128) ? active_end : 128;
        exp_valid_cnt = active_end - 1;
        n_valid = 0;
        scan_start = 1'b1; first_sprite = first;
        tick();
        scan_start = 1'b0; first_sprite = $urandom_range(0, 127);
        for (int c = 1; c <= 135; c++) begin
            scan_abort = (c == abort_at);
            n_checks++;
            if ({scan_busy, spr_valid, scan_done} !==
                {c <= active_end, (c >= 2) && (c <= active_end), (abort_at == 0) && (c == 129)}) begin
                n_fail++;
                $display("FAIL scan_ctrl c=%0d: got busy=%b valid=%b done=%b, want busy=%b valid=%b done=%b",
                         c, scan_busy, spr_valid, scan_done, c <= active_end,
                         (c >= 2) && (c <= active_end), (abort_at == 0) && (c == 129));
            end
            if (c <= issue_end) begin
                exp_idx = 7'((int'(first) + c - 1) % 128);
                n_checks++;
                if (ram_addr_b !== exp_idx) begin
                    n_fail++;
                    $display("FAIL scan_addr c=%0d: got %0d, want %0d", c, ram_addr_b, exp_idx);
                end
            end
            if (spr_valid) begin
                n_valid++;
                exp_idx = 7'((int'(first) + c - 2) % 128);
                scan_got[spr_idx] = spr_bits;
                n_checks++;
                if ({spr_idx, spr_bits} !== {exp_idx, exp_bits(int'(exp_idx))}) begin
                    n_fail++;
                    $display("FAIL scan_data c=%0d: got idx=%0d bits=%b, want idx=%0d bits=%b",
                             c, spr_idx, spr_bits, exp_idx, exp_bits(int'(exp_idx)));
                end
            end
            tick();
        end
        scan_abort = 1'b0;
        n_checks++;
        if (n_valid != exp_valid_cnt) begin
            n_fail++;
            $display("FAIL scan_valid_count: got %0d, want %0d", n_valid, exp_valid_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", all_outs());
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h, want 0", all_outs());
        end
    endtask

    task automatic test_clear();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
            end
            n_checks++;
            if ({clr_busy, ram_wren_a, ram_addr_a, ram_data_a, cpu_ack} !==
                {1'b1, 1'b1, 5'(k), 8'h00, 1'b0}) begin
                n_fail++;
                $display("FAIL clear_write k=%0d: got busy=%b wren=%b addr=%0d data=%h ack=%b, want 1 1 %0d 00 0",
                         k, clr_busy, ram_wren_a, ram_addr_a, ram_data_a, cpu_ack, k);
            end
            tick();
        end
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        n_checks++;
        if ({cpu_ack, clr_busy, ram_wren_a, ram_addr_a} !== {1'b1, 1'b0, 1'b0, 5'd7}) begin
            n_fail++;
            $display("FAIL clear_cpu_ack: got ack=%b busy=%b wren=%b addr=%0d, want 1 0 0 7",
                     cpu_ack, clr_busy, ram_wren_a, ram_addr_a);
        end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL clear_cpu_read: got rvalid=%b rdata=%h, want 1 00", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_preload_scan();
        cpu_access(1'b1, 5'd1,  8'h08, 8'h00);
        cpu_access(1'b1, 5'd31, 8'hC0, 8'h00);
        cpu_access(1'b1, 5'd0,  8'h01, 8'h00);
        run_scan(7'd127, 0);
        n_checks++;
        if ({scan_got[5], scan_got[127], scan_got[0], scan_got[1]} !== 8'b10_11_01_00) begin
            n_fail++;
            $display("FAIL preload_bits: got idx5=%b idx127=%b idx0=%b idx1=%b, want 10 11 01 00",
                     scan_got[5], scan_got[127], scan_got[0], scan_got[1]);
        end
    endtask

    task automatic test_abort();
        run_scan(7'($urandom_range(0, 127)), 10);
        run_scan(7'($urandom_range(0, 127)), 0);
    endtask

    task automatic test_cpu_rw();
        cpu_access(1'b1, 5'd3, 8'hA5, 8'h00);
        cpu_access(1'b0, 5'd3, 8'h00, 8'hA5);
    endtask

    task automatic test_both_start();
        clr_start = 1'b1; scan_start = 1'b1; first_sprite = 7'd40;
        tick();
        clr_start = 1'b0; scan_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            n_checks++;
            if ({clr_busy, ram_wren_a, scan_busy, spr_valid} !== {c <= 32, c <= 32, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL both_start c=%0d: got clr=%b wren=%b scan=%b valid=%b, want %b %b 0 0",
                         c, clr_busy, ram_wren_a, scan_busy, spr_valid, c <= 32, c <= 32);
            end
            tick();
        end
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int it = 0; it < 3; it++) begin
            for (int w = 0; w < 8; w++)
                cpu_access(1'b1, 5'($urandom_range(0, 31)), 8'($urandom), 8'h00);
            for (int r = 0; r < 3; r++) begin
                a = 5'($urandom_range(0, 31));
                cpu_access(1'b0, a, 8'h00, ref_mem[a]);
            end
            run_scan(7'($urandom_range(0, 127)), 0);
        end
    endtask

    task automatic test_reset_mid_clear();
        int waited;
        cpu_access(1'b1, 5'd20, 8'h3C, 8'h00);
        cpu_access(1'b1, 5'd5,  8'h77, 8'h00);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        waited = 1;
        while (!(clr_busy && ram_addr_a == 5'd12) && waited < 40) begin
            tick();
            waited++;
        end
        n_checks++;
        if (waited != 13) begin
            n_fail++;
            $display("FAIL clear_reach_12: got cycle %0d, want 13", waited);
        end
        for (int i = 0; i <= 12; i++) ref_mem[i] = 8'h00;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd20;
        for (int r = 0; r < 2; r++) begin
            tick();
            n_checks++;
            if (all_outs() !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_clear r=%0d: got %h, want 0", r, all_outs());
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({cpu_ack, ram_addr_a, ram_wren_a, clr_busy} !== {1'b1, 5'd20, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL pending_req_after_reset: got ack=%b addr=%0d wren=%b clr=%b, want 1 20 0 0",
                     cpu_ack, ram_addr_a, ram_wren_a, clr_busy);
        end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL read_after_reset: got rvalid=%b rdata=%h, want 1 3c", cpu_rvalid, cpu_rdata);
        end
        cpu_access(1'b0, 5'd5, 8'h00, 8'h00);
        run_scan(7'($urandom_range(0, 127)), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; clr_start = 1'b0; scan_start = 1'b0; scan_abort = 1'b0;
        first_sprite = 7'd0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 8'h00;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 128; i++) scan_got[i] = 2'b00;
        test_reset();
        test_clear();
        test_preload_scan();
        test_abort();
        test_cpu_rw();
        test_both_start();
        test_random();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
